keycode_hex_display: RTL and testbench

- Parametrised successor to the fixed two-digit keycode readout. Drives NUM_DIGITS seven-segment displays from the NIOS keycode PIO.
- Adds a key-press history buffer, a saturating press counter, display modes, freeze, clear, and blink of the newest entry.
- Sits between the nios_system keycode export and the HEX outputs in the top level.

---
 rtl/keycode_hex_display_if.sv | 25 ++
 rtl/keycode_hex_display.sv | 139 +++++++++++++
 tb/tb_keycode_hex_display.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/keycode_hex_display_if.sv
// Bundle of keycode inputs, control lines and display outputs for keycode_hex_display.
// new_key is a valid-only strobe: high for exactly one cycle per accepted key, no ready/backpressure; key_count is already updated when it is high.
interface keycode_hex_display_if #(
  parameter int KEY_W      = 8,
  parameter int NUM_DIGITS = 8,
  parameter int CNT_W      = 16
);
  logic [KEY_W-1:0]        keycode;
  logic [1:0]              mode;
  logic                    freeze;
  logic                    clear;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    new_key;
  logic [CNT_W-1:0]        key_count;

  modport master (
    output keycode, mode, freeze, clear,
    input  hex_out, new_key, key_count
  );

  modport slave (
    input  keycode, mode, freeze, clear,
    output hex_out, new_key, key_count
  );
endinterface

// File: rtl/keycode_hex_display.sv
// Seven-segment readout of the NIOS keycode PIO with press history, saturating
// press counter, display modes, freeze, clear and blink of the newest entry.
module keycode_hex_display #(
  parameter int KEY_W      = 8,
  parameter int NUM_DIGITS = 8,
  parameter int CNT_W      = 16,
  parameter int BLINK_DIV  = 25_000_000
) (
  input logic              Clk,
  input logic              Reset,
  keycode_hex_display_if.slave bus
);
  localparam int DPK   = KEY_W / 4;
  localparam int DEPTH = NUM_DIGITS / DPK;
  localparam int BW    = $clog2(BLINK_DIV);
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam int NIB_W = 4 * NUM_DIGITS;

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [KEY_W-1:0]            keycode_q, keycode_d;
  logic [DEPTH-1:0][KEY_W-1:0] hist_q, hist_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        new_key_q, new_key_d;
  logic [BW-1:0]               blink_cnt_q, blink_cnt_d;
  logic                        blink_ph_q, blink_ph_d;
  logic [HEX_W-1:0]            hex_q, hex_d;
  logic                        key_event;
  logic [NIB_W-1:0]            cnt_ext;

  // keycode_q tracks the input even while frozen, so a key held across the
  // freeze release already matches and does not fire.
  assign key_event = (bus.keycode != keycode_q) && (bus.keycode != '0) &&
                     !bus.freeze && !bus.clear;

  always_comb begin : history_update
    keycode_d = bus.keycode;
    hist_d    = hist_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    new_key_d = 1'b0;
    if (bus.clear) begin
      hist_d  = '0;
      valid_d = '0;
      cnt_d   = '0;
    end else if (key_event) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        hist_d[k]  = hist_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      hist_d[0]  = bus.keycode;
      valid_d[0] = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      new_key_d = 1'b1;
    end
  end

  always_comb begin : blink_update
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin : display
    cnt_ext = NIB_W'(cnt_q);
    hex_d   = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      case (bus.mode)
        2'd0: begin
          if (d < DPK) begin
            hex_d[7*d +: 7] = seg7(keycode_q[4*(d % DPK) +: 4]);
          end
        end
        2'd2: hex_d[7*d +: 7] = seg7(cnt_ext[4*d +: 4]);
        default: begin
          // Modes 1 and 3; mode 3 hides the newest group during blink phase 1.
          if (valid_q[d / DPK] &&
              !(bus.mode == 2'd3 && blink_ph_q && (d / DPK) == 0)) begin
            hex_d[7*d +: 7] = seg7(hist_q[d / DPK][4*(d % DPK) +: 4]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      keycode_q   <= '0;
      hist_q      <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      new_key_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      hex_q       <= '1;
    end else begin
      keycode_q   <= keycode_d;
      hist_q      <= hist_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      new_key_q   <= new_key_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      hex_q       <= hex_d;
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.new_key   = new_key_q;
  assign bus.key_count = cnt_q;
endmodule

// File: tb/tb_keycode_hex_display.sv
// Directed scoreboard bench for keycode_hex_display (small counter and fast
// blink so saturation and blink fit in a short run).
module tb_keycode_hex_display;
  localparam int KEY_W      = 8;
  localparam int NUM_DIGITS = 8;
  localparam int CNT_W      = 4;
  localparam int BLINK_DIV  = 4;
  localparam int HW         = 7 * NUM_DIGITS;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00;
  localparam logic [6:0] SA = 7'h08, SC = 7'h46, SD = 7'h21, SE = 7'h06;
  localparam logic [6:0] SF = 7'h0E, BL = 7'h7F;
  localparam logic [HW-1:0] ALL_BL = {8{7'h7F}};

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  keycode_hex_display_if #(.KEY_W(KEY_W), .NUM_DIGITS(NUM_DIGITS), .CNT_W(CNT_W)) bus ();

  keycode_hex_display #(
    .KEY_W(KEY_W), .NUM_DIGITS(NUM_DIGITS), .CNT_W(CNT_W), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  // Scoreboard state
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [HW-1:0]    exp_hex_q[$];
  logic             chk_hex = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected count on every new_key pulse, an expected
  // display image whenever the driver requests a display sample.
  always @(negedge clk) begin
    if (chk_hex) begin
      if (exp_hex_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL hex_out: sample requested with empty expectation queue");
      end else begin
        check("hex_out", 64'(bus.hex_out), 64'(exp_hex_q.pop_front()));
      end
    end
    if (bus.new_key === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL new_key: unexpected pulse, key_count=%0h", bus.key_count);
      end else begin
        check("new_key_count", 64'(bus.key_count), 64'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_hex(input logic [HW-1:0] e);
    exp_hex_q.push_back(e);
    chk_hex = 1'b1;
    @(negedge clk);
    #1;
    chk_hex = 1'b0;
  endtask

  task automatic press(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] cnt_after);
    exp_q.push_back(cnt_after);
    bus.keycode = k;
    step();
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [KEY_W-1:0] k);
    rst        = 1'b1;
    bus.mode   = m;
    bus.keycode = k;
    bus.freeze = 1'b0;
    bus.clear  = 1'b0;
    step(2);
    check("reset_hex", 64'(bus.hex_out), 64'(ALL_BL));
    check("reset_count", 64'(bus.key_count), 64'd0);
    check("reset_new_key", 64'(bus.new_key), 64'd0);
    rst = 1'b0;
  endtask

  logic [HW-1:0] g0;

  initial begin
    bus.keycode = '0;
    bus.mode    = 2'd0;
    bus.freeze  = 1'b0;
    bus.clear   = 1'b0;

    // Live mode: 1C shows after two edges; first edge still shows keycode_q=00
    exp_q.push_back(CNT_W'(1));
    do_reset(2'd0, 8'h1C);
    step();
    expect_hex({BL, BL, BL, BL, BL, BL, S0, S0});
    step();
    expect_hex({BL, BL, BL, BL, BL, BL, S1, SC});
    step(3);
    check_drained("live_pulses");
    check("live_count", 64'(bus.key_count), 64'd1);

    // History: five presses separated by releases, oldest evicted
    do_reset(2'd1, 8'h00);
    press(8'h04, CNT_W'(1)); bus.keycode = 8'h00; step();
    press(8'h05, CNT_W'(2)); bus.keycode = 8'h00; step();
    press(8'h06, CNT_W'(3)); bus.keycode = 8'h00; step();
    press(8'h07, CNT_W'(4)); bus.keycode = 8'h00; step();
    press(8'h08, CNT_W'(5));
    step();
    expect_hex({S0, S5, S0, S6, S0, S7, S0, S8});
    check_drained("history_pulses");
    check("history_count", 64'(bus.key_count), 64'd5);

    // Long hold then direct change, then freeze behaviour
    do_reset(2'd1, 8'h00);
    press(8'h1C, CNT_W'(1));
    step(99);
    press(8'h1D, CNT_W'(2));
    step();
    expect_hex({BL, BL, BL, BL, S1, SC, S1, SD});
    bus.freeze  = 1'b1;
    bus.keycode = 8'h2A;
    step(3);
    expect_hex({BL, BL, BL, BL, S1, SC, S1, SD});
    bus.freeze = 1'b0;
    step(3);
    expect_hex({BL, BL, BL, BL, S1, SC, S1, SD});
    check_drained("hold_freeze_pulses");
    check("hold_freeze_count", 64'(bus.key_count), 64'd2);
    bus.mode = 2'd0;
    step();
    expect_hex({BL, BL, BL, BL, BL, BL, S2, SA});
    bus.mode = 2'd1;

    // Clear beats a simultaneous key; next distinct key records normally
    bus.keycode = 8'h00;
    step();
    bus.clear   = 1'b1;
    bus.keycode = 8'h0B;
    step();
    bus.clear = 1'b0;
    step();
    expect_hex(ALL_BL);
    check("clear_count", 64'(bus.key_count), 64'd0);
    press(8'h0E, CNT_W'(1));
    step();
    expect_hex({BL, BL, BL, BL, BL, BL, S0, SE});
    bus.mode = 2'd2;
    step();
    expect_hex({S0, S0, S0, S0, S0, S0, S0, S1});
    check_drained("clear_pulses");

    // Counter saturation over 17 distinct presses
    do_reset(2'd2, 8'h00);
    for (int i = 1; i <= 17; i++) begin
      press(KEY_W'(i), CNT_W'((i < 15) ? i : 15));
      if (i == 15) begin
        check_drained("sat_pulses_15");
        check("sat_count_15", 64'(bus.key_count), 64'hF);
      end
    end
    step();
    expect_hex({S0, S0, S0, S0, S0, S0, S0, SF});
    check("sat_count_17", 64'(bus.key_count), 64'hF);
    check_drained("sat_pulses_17");

    // Blink: edge n after release shows group 0 for n=2..4, 9..12, 17
    g0 = {BL, BL, BL, BL, BL, BL, S3, SC};
    exp_q.push_back(CNT_W'(1));
    do_reset(2'd3, 8'h3C);
    for (int n = 1; n <= 17; n++) begin
      step();
      if ((n >= 2 && n <= 4) || (n >= 9 && n <= 12) || n == 17) expect_hex(g0);
      else expect_hex(ALL_BL);
    end

    // Asynchronous reset mid-cycle blanks the display without a clock edge
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_hex", 64'(bus.hex_out), 64'(ALL_BL));
    check("async_reset_new_key", 64'(bus.new_key), 64'd0);
    check("async_reset_count", 64'(bus.key_count), 64'd0);
    step(2);
    rst = 1'b0;
    check_drained("blink_pulses");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog timeout");
  end
endmodule
